// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU issue controller: ALU op codes,
// RV32 opcode/funct constants and the controller state encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_NOP = 4'b0000,
    ALU_AND = 4'b0001,
    ALU_OR  = 4'b0010,
    ALU_ADD = 4'b0011,
    ALU_SUB = 4'b0100,
    ALU_XOR = 4'b0101,
    ALU_MUL = 4'b0110
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of one RV32 instruction into an ALU op, operand-2
// select, destination register and branch/illegal flags.
module alu_decode
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output alu_op_t         op,
  output logic            use_imm,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic            wb_en,
  output logic            branch,
  output logic            bne,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       writes_rd;
  logic       unused_src_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm    = {{(XLEN-12){instr[31]}}, instr[31:20]};
  // Register specifiers arrive as operand data; the fields themselves are not needed.
  assign unused_src_fields = ^instr[19:15];

  always_comb begin
    op        = ALU_NOP;
    use_imm   = 1'b0;
    writes_rd = 1'b0;
    branch    = 1'b0;
    bne       = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        writes_rd = 1'b1;
        case ({funct7, funct3})
          {F7_BASE,   F3_ADD_SUB}: op = ALU_ADD;
          {F7_ALT,    F3_ADD_SUB}: op = ALU_SUB;
          {F7_BASE,   F3_XOR}:     op = ALU_XOR;
          {F7_BASE,   F3_OR}:      op = ALU_OR;
          {F7_BASE,   F3_AND}:     op = ALU_AND;
          {F7_MULDIV, F3_ADD_SUB}: op = ALU_MUL;
          default: begin
            writes_rd = 1'b0;
            illegal   = 1'b1;
          end
        endcase
      end
      OPC_OP_IMM: begin
        writes_rd = 1'b1;
        use_imm   = 1'b1;
        case (funct3)
          F3_ADD_SUB: op = ALU_ADD;
          F3_XOR:     op = ALU_XOR;
          F3_OR:      op = ALU_OR;
          F3_AND:     op = ALU_AND;
          default: begin
            writes_rd = 1'b0;
            use_imm   = 1'b0;
            illegal   = 1'b1;
          end
        endcase
      end
      OPC_BRANCH: begin
        case (funct3)
          F3_BEQ: begin
            op     = ALU_SUB;
            branch = 1'b1;
          end
          F3_BNE: begin
            op     = ALU_SUB;
            branch = 1'b1;
            bne    = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    rd    = writes_rd ? instr[11:7] : 5'd0;
    wb_en = writes_rd && (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage ALU initiator: accepts an instruction, drives the external
// combinational ALU for ISSUE/CAPTURE, and returns a writeback/branch response.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic [XLEN-1:0] alu_input1,
  output logic [XLEN-1:0] alu_input2,
  output logic [3:0]      alu_control,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_branch,
  output logic            out_taken,
  output logic            out_illegal
);

  state_t state_q, state_d;

  alu_op_t         dec_op;
  logic            dec_use_imm;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_rd;
  logic            dec_wb_en, dec_branch, dec_bne, dec_illegal;

  alu_op_t         op_q;
  logic [XLEN-1:0] in1_q, in2_q, result_q;
  logic [4:0]      rd_q;
  logic            wb_en_q, branch_q, bne_q, illegal_q, zero_q;
  logic            alu_active, accept, resp;

  alu_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .op      (dec_op),
    .use_imm (dec_use_imm),
    .imm     (dec_imm),
    .rd      (dec_rd),
    .wb_en   (dec_wb_en),
    .branch  (dec_branch),
    .bne     (dec_bne),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    alu_active = 1'b0;
    resp       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = dec_illegal ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        alu_active = 1'b1;
        state_d    = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        alu_active = 1'b1;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        resp = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = (state_q == ST_IDLE) && in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= ALU_NOP;
      in1_q     <= '0;
      in2_q     <= '0;
      rd_q      <= '0;
      wb_en_q   <= 1'b0;
      branch_q  <= 1'b0;
      bne_q     <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= dec_op;
        in1_q     <= in_rs1_data;
        in2_q     <= dec_use_imm ? dec_imm : in_rs2_data;
        rd_q      <= dec_rd;
        wb_en_q   <= dec_wb_en;
        branch_q  <= dec_branch;
        bne_q     <= dec_bne;
        illegal_q <= dec_illegal;
      end
      if (state_q == ST_CAPTURE) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
      end
    end
  end

  // ALU drive and response are gated by state so idle/reset outputs read as zero.
  assign alu_input1  = alu_active ? in1_q : '0;
  assign alu_input2  = alu_active ? in2_q : '0;
  assign alu_control = alu_active ? op_q : ALU_NOP;

  assign out_valid   = resp;
  assign out_result  = (resp && !branch_q && !illegal_q) ? result_q : '0;
  assign out_rd      = resp ? rd_q : 5'd0;
  assign out_wb_en   = resp && wb_en_q;
  assign out_branch  = resp && branch_q;
  assign out_taken   = resp && branch_q && (bne_q ? !zero_q : zero_q);
  assign out_illegal = resp && illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a behavioural ALU on the drive side
// and an instruction-level reference model for the expected responses.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1_data, in_rs2_data;
  logic [31:0] alu_input1, alu_input2;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wb_en, out_branch, out_taken, out_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .alu_input1  (alu_input1),
    .alu_input2  (alu_input2),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_wb_en   (out_wb_en),
    .out_branch  (out_branch),
    .out_taken   (out_taken),
    .out_illegal (out_illegal)
  );

  // Behavioural ALU the controller drives.
  always_comb begin
    case (alu_control)
      4'b0001: alu_result = alu_input1 & alu_input2;
      4'b0010: alu_result = alu_input1 | alu_input2;
      4'b0011: alu_result = alu_input1 + alu_input2;
      4'b0100: alu_result = alu_input1 - alu_input2;
      4'b0101: alu_result = alu_input1 ^ alu_input2;
      4'b0110: alu_result = alu_input1 * alu_input2;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wb, br, tk, ill;
    logic [3:0]  ctrl;
    logic [31:0] a, b;
  } exp_t;

  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t e;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic signed [11:0] i12;
    logic [31:0] immv;
    logic        reg_op;
    opc  = ins[6:0];
    f3   = ins[14:12];
    f7   = ins[31:25];
    i12  = ins[31:20];
    immv = 32'(int'(i12));
    e = '{result: 32'd0, rd: 5'd0, wb: 1'b0, br: 1'b0, tk: 1'b0, ill: 1'b1, ctrl: 4'd0, a: 32'd0, b: 32'd0};
    reg_op = 1'b0;
    if (opc == 7'h33) begin
      reg_op = 1'b1;
      e.a = rs1;
      e.b = rs2;
      if      (f7 == 7'h00 && f3 == 3'd0) begin e.ctrl = 4'd3; e.result = rs1 + rs2; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin e.ctrl = 4'd4; e.result = rs1 - rs2; end
      else if (f7 == 7'h00 && f3 == 3'd4) begin e.ctrl = 4'd5; e.result = rs1 ^ rs2; end
      else if (f7 == 7'h00 && f3 == 3'd6) begin e.ctrl = 4'd2; e.result = rs1 | rs2; end
      else if (f7 == 7'h00 && f3 == 3'd7) begin e.ctrl = 4'd1; e.result = rs1 & rs2; end
      else if (f7 == 7'h01 && f3 == 3'd0) begin e.ctrl = 4'd6; e.result = 32'(64'(rs1) * 64'(rs2)); end
      else reg_op = 1'b0;
    end else if (opc == 7'h13) begin
      reg_op = 1'b1;
      e.a = rs1;
      e.b = immv;
      if      (f3 == 3'd0) begin e.ctrl = 4'd3; e.result = rs1 + immv; end
      else if (f3 == 3'd4) begin e.ctrl = 4'd5; e.result = rs1 ^ immv; end
      else if (f3 == 3'd6) begin e.ctrl = 4'd2; e.result = rs1 | immv; end
      else if (f3 == 3'd7) begin e.ctrl = 4'd1; e.result = rs1 & immv; end
      else reg_op = 1'b0;
    end else if (opc == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
      e.ill  = 1'b0;
      e.br   = 1'b1;
      e.ctrl = 4'd4;
      e.a    = rs1;
      e.b    = rs2;
      e.tk   = (f3 == 3'd0) ? (rs1 == rs2) : (rs1 != rs2);
    end
    if (reg_op) begin
      e.ill = 1'b0;
      e.rd  = ins[11:7];
      e.wb  = (ins[11:7] != 5'd0);
    end else if (!e.br) begin
      e.ctrl   = 4'd0;
      e.result = 32'd0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_resp(input exp_t e);
    check("out_valid",   64'(out_valid),   64'(1));
    check("out_result",  64'(out_result),  64'(e.result));
    check("out_rd",      64'(out_rd),      64'(e.rd));
    check("out_wb_en",   64'(out_wb_en),   64'(e.wb));
    check("out_branch",  64'(out_branch),  64'(e.br));
    check("out_taken",   64'(out_taken),   64'(e.tk));
    check("out_illegal", 64'(out_illegal), 64'(e.ill));
    check("resp_in_ready", 64'(in_ready),  64'(0));
    check("resp_alu_ctrl", 64'(alu_control), 64'(0));
  endtask

  task automatic recover();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Starts at a negedge with the DUT idle; returns at a negedge after the response completes.
  task automatic run_txn(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2, input int hold);
    exp_t e;
    int   n;
    e = ref_model(ins, rs1, rs2);
    check("idle_in_ready", 64'(in_ready), 64'(1));
    in_valid    = 1'b1;
    in_instr    = ins;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    @(negedge clk);
    in_valid    = 1'b0;
    in_instr    = $urandom;
    in_rs1_data = $urandom;
    in_rs2_data = $urandom;
    n = 0;
    while (!out_valid && n < 8) begin
      check("alu_control", 64'(alu_control), 64'(e.ctrl));
      check("alu_input1",  64'(alu_input1),  64'(e.a));
      check("alu_input2",  64'(alu_input2),  64'(e.b));
      check("busy_in_ready", 64'(in_ready),  64'(0));
      n++;
      @(negedge clk);
    end
    check("cycles_to_resp", 64'(n), e.ill ? 64'(0) : 64'(2));
    if (!out_valid) begin
      recover();
      return;
    end
    for (int i = 0; i < hold; i++) begin
      check_resp(e);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check_resp(e);
    @(negedge clk);
    out_ready = 1'b0;
    check("after_valid", 64'(out_valid), 64'(0));
    check("after_in_ready", 64'(in_ready), 64'(1));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [4:0]  rdv, r1, r2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          k;
    rdv = 5'($urandom);
    r1  = 5'($urandom);
    r2  = 5'($urandom);
    k   = int'($urandom_range(0, 9));
    w   = $urandom;
    if (k <= 3) begin
      case ($urandom_range(0, 5))
        0: begin f7 = 7'h00; f3 = 3'd0; end
        1: begin f7 = 7'h20; f3 = 3'd0; end
        2: begin f7 = 7'h00; f3 = 3'd4; end
        3: begin f7 = 7'h00; f3 = 3'd6; end
        4: begin f7 = 7'h00; f3 = 3'd7; end
        default: begin f7 = 7'h01; f3 = 3'd0; end
      endcase
      w = {f7, r2, r1, f3, rdv, 7'h33};
    end else if (k <= 5) begin
      case ($urandom_range(0, 3))
        0: f3 = 3'd0;
        1: f3 = 3'd4;
        2: f3 = 3'd6;
        default: f3 = 3'd7;
      endcase
      w = {w[31:20], r1, f3, rdv, 7'h13};
    end else if (k <= 7) begin
      f3 = 3'($urandom_range(0, 1));
      w = {w[31:25], r2, r1, f3, w[11:7], 7'h63};
    end else if (k == 8) begin
      w = {w[31:7], (w[0] ? 7'h33 : 7'h13)};
    end
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, ins;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_instr    = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  64'(in_ready),    64'(1));
    check("rst_out_valid", 64'(out_valid),   64'(0));
    check("rst_alu_ctrl",  64'(alu_control), 64'(0));
    check("rst_alu_in1",   64'(alu_input1),  64'(0));
    check("rst_out_result", 64'(out_result), 64'(0));
    check("rst_out_flags", 64'({out_wb_en, out_branch, out_taken, out_illegal, out_rd}), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Reset while a response is stalled.
    in_valid = 1'b1; in_instr = 32'h002081B3; in_rs1_data = 32'd5; in_rs2_data = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 6 && !out_valid; i++) @(negedge clk);
    check("pre_reset_valid", 64'(out_valid), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("resp_reset_valid", 64'(out_valid), 64'(0));
    check("resp_reset_ready", 64'(in_ready),  64'(1));
    check("resp_reset_ctrl",  64'(alu_control), 64'(0));

    // Reset during ISSUE aborts without a response.
    in_valid = 1'b1; in_instr = 32'h402081B3;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_valid", 64'(out_valid), 64'(0));
      @(negedge clk);
    end

    run_txn(32'h002081B3, 32'd5, 32'd7, 0);
    run_txn(32'h002081B3, 32'd5, 32'd7, 5);
    run_txn(32'h402081B3, 32'd5, 32'd7, 1);
    run_txn(32'h022081B3, 32'h10000, 32'h10000, 0);
    run_txn(32'hFFF08293, 32'd0, 32'd123, 0);
    run_txn(32'h00208063, 32'd9, 32'd9, 0);
    run_txn(32'h00209063, 32'd9, 32'd9, 0);
    run_txn(32'h00209063, 32'd9, 32'd4, 0);
    run_txn(32'h0000007F, 32'd1, 32'd2, 2);
    run_txn(32'h00208033, 32'd1, 32'd2, 0);

    for (int t = 0; t < 300; t++) begin
      ins = rand_instr();
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) begin
        a = 32'($urandom_range(0, 20));
        b = 32'($urandom_range(0, 20));
      end
      run_txn(ins, a, b, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
